// File: rtl/cond_logic_pkg.sv
// rtl/cond_logic_pkg.sv - condition codes and NZCV bit positions for the conditional-execution stage
package cond_logic_pkg;
  typedef logic [3:0] nzcv_t;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
endpackage

// File: rtl/cond_logic_if.sv
// rtl/cond_logic_if.sv - decode/FSM strobes in, architectural write enables and flags out
interface cond_logic_if;
  import cond_logic_pkg::*;

  logic [3:0] Cond;
  nzcv_t      ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  nzcv_t      Flags;
  logic       CondEx;

  modport master (
    output Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
    input  PCWrite, RegWrite, MemWrite, Flags, CondEx
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
    output PCWrite, RegWrite, MemWrite, Flags, CondEx
  );
endinterface

// File: rtl/cond_logic_cond_check.sv
// rtl/cond_logic_cond_check.sv - combinational ARM condition evaluation against NZCV
module cond_check
  import cond_logic_pkg::*;
(
  input  logic [3:0] cond,
  input  nzcv_t      flags,
  output logic       cond_ex
);
  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Anything outside EQ..LE (AL, 4'hF, unknown) executes unconditionally
  always_comb begin
    cond_ex = 1'b1;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      default: cond_ex = 1'b1;
    endcase
  end
endmodule

// File: rtl/cond_logic.sv
// rtl/cond_logic.sv - NZCV flag storage, condition gating of write strobes, one-cycle condition delay
module cond_logic
  import cond_logic_pkg::*;
#(
  parameter nzcv_t RESET_FLAGS = 4'b0000
) (
  input  logic         clk,
  input  logic         reset,
  cond_logic_if.slave  bus
);
  nzcv_t flags_q, flags_d;
  logic  cond_ex_dly_q, cond_ex_dly_d;
  logic  cond_ex;

  cond_check u_cond_check (
    .cond    (bus.Cond),
    .flags   (flags_q),
    .cond_ex (cond_ex)
  );

  // Flag halves use the undelayed result: the write lands at the end of execute
  always_comb begin
    flags_d = flags_q;
    if (bus.FlagW[1] && cond_ex)
      flags_d[FLAG_N:FLAG_Z] = bus.ALUFlags[FLAG_N:FLAG_Z];
    if (bus.FlagW[0] && cond_ex)
      flags_d[FLAG_C:FLAG_V] = bus.ALUFlags[FLAG_C:FLAG_V];
    cond_ex_dly_d = cond_ex;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q       <= RESET_FLAGS;
      cond_ex_dly_q <= 1'b0;
    end else begin
      flags_q       <= flags_d;
      cond_ex_dly_q <= cond_ex_dly_d;
    end
  end

  // Fetch's NextPC bypasses the condition so the PC always advances
  assign bus.PCWrite  = (bus.PCS & cond_ex_dly_q) | bus.NextPC;
  assign bus.RegWrite = bus.RegW & cond_ex_dly_q;
  assign bus.MemWrite = bus.MemW & cond_ex_dly_q;
  assign bus.Flags    = flags_q;
  assign bus.CondEx   = cond_ex;
endmodule
